// File: rtl/axi4lite_stress_sequencer_if.sv
// Bus-side signals between the stress sequencer and the AXI4-Lite random traffic master:
// handshake strobes {R,AR,B,W,AW} flow in, per-channel stall probabilities flow out.
interface axi4lite_stress_sequencer_if #(
  parameter int PROB_W = 8
);
  logic [4:0]        hs;
  logic [PROB_W-1:0] pr_aw_stall;
  logic [PROB_W-1:0] pr_w_stall;
  logic [PROB_W-1:0] pr_b_stall;
  logic [PROB_W-1:0] pr_ar_stall;
  logic [PROB_W-1:0] pr_r_stall;

  modport master (
    input  hs,
    output pr_aw_stall, pr_w_stall, pr_b_stall, pr_ar_stall, pr_r_stall
  );

  modport slave (
    output hs,
    input  pr_aw_stall, pr_w_stall, pr_b_stall, pr_ar_stall, pr_r_stall
  );
endinterface

// File: rtl/axi4lite_stress_sequencer.sv
// Phase sequencer for AXI4-Lite stress traffic: CLEAN -> STRESS_REQ -> STRESS_RSP -> DRAIN,
// with outstanding-transaction tracking, underflow detection and a hang watchdog.
module axi4lite_stress_sequencer #(
  parameter int                PROB_W    = 8,
  parameter int                CNT_W     = 16,
  parameter int                TIMEOUT_W = 12,
  parameter logic [PROB_W-1:0] PR_HI     = PROB_W'(8'hC0)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [CNT_W-1:0]     i_phaseTxns,
  input  logic [TIMEOUT_W-1:0] i_timeout,
  axi4lite_stress_sequencer_if.master bus,
  output logic [2:0]           o_state,
  output logic [CNT_W-1:0]     o_nWr,
  output logic [CNT_W-1:0]     o_nRd,
  output logic                 o_protoErr
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0, ST_CLEAN = 3'd1, ST_SREQ = 3'd2, ST_SRSP = 3'd3,
    ST_DRAIN = 3'd4, ST_DONE  = 3'd5, ST_HANG = 3'd6
  } state_t;

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      wr_out_r, wr_out_s, rd_out_r, rd_out_s;
  logic [CNT_W-1:0]      nwr_r, nrd_r, phase_r;
  logic [CNT_W:0]        phase_sum_s;
  logic [TIMEOUT_W-1:0]  wd_r, wd_inc_s;
  logic [PROB_W-1:0]     pr_req_r, pr_req_s, pr_rsp_r, pr_rsp_s;
  logic                  proto_r, wr_err_s, rd_err_s;
  logic                  hs_aw_s, hs_b_s, hs_ar_s, hs_r_s, any_hs_s;
  logic                  active_s, in_phase_s, phase_done_s, wd_exp_s, start_ok_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    else                    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign hs_aw_s  = bus.hs[0];
  assign hs_b_s   = bus.hs[2];
  assign hs_ar_s  = bus.hs[3];
  assign hs_r_s   = bus.hs[4];
  assign any_hs_s = |bus.hs;

  assign in_phase_s = (state_r == ST_CLEAN) || (state_r == ST_SREQ) || (state_r == ST_SRSP);
  assign active_s   = in_phase_s || (state_r == ST_DRAIN);
  assign start_ok_s = i_start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_HANG));

  assign phase_sum_s  = {1'b0, phase_r} + {{CNT_W{1'b0}}, hs_b_s} + {{CNT_W{1'b0}}, hs_r_s};
  assign phase_done_s = phase_sum_s >= {1'b0, i_phaseTxns};

  // Watchdog expires on the edge where its count would reach the limit; any handshake resets it instead.
  assign wd_inc_s = (wd_r == {TIMEOUT_W{1'b1}}) ? wd_r : wd_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  assign wd_exp_s = active_s && !any_hs_s && (i_timeout != {TIMEOUT_W{1'b0}}) && (wd_inc_s == i_timeout);

  // Outstanding write/read tracking; an unmatched response holds the count at zero and flags an error.
  always_comb begin
    wr_out_s = wr_out_r;
    wr_err_s = 1'b0;
    rd_out_s = rd_out_r;
    rd_err_s = 1'b0;
    if (hs_aw_s && !hs_b_s) begin
      wr_out_s = sat_inc(wr_out_r);
    end else if (hs_b_s && !hs_aw_s) begin
      if (wr_out_r == {CNT_W{1'b0}}) wr_err_s = 1'b1;
      else                           wr_out_s = wr_out_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      wr_out_s = wr_out_r;
    end
    if (hs_ar_s && !hs_r_s) begin
      rd_out_s = sat_inc(rd_out_r);
    end else if (hs_r_s && !hs_ar_s) begin
      if (rd_out_r == {CNT_W{1'b0}}) rd_err_s = 1'b1;
      else                           rd_out_s = rd_out_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      rd_out_s = rd_out_r;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // Next state: abort beats phase advance, which beats watchdog expiry.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_HANG: begin
        if (i_start) state_s = ST_CLEAN;
        else         state_s = state_r;
      end
      ST_CLEAN, ST_SREQ, ST_SRSP: begin
        if (i_abort)           state_s = ST_DRAIN;
        else if (phase_done_s) state_s = (state_r == ST_CLEAN) ? ST_SREQ :
                                         (state_r == ST_SREQ)  ? ST_SRSP : ST_DRAIN;
        else if (wd_exp_s)     state_s = ST_HANG;
        else                   state_s = state_r;
      end
      ST_DRAIN: begin
        if ((wr_out_s == {CNT_W{1'b0}}) && (rd_out_s == {CNT_W{1'b0}})) state_s = ST_DONE;
        else if (wd_exp_s)                                              state_s = ST_HANG;
        else                                                            state_s = state_r;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Probability outputs decoded from the next state so they change on the same edge as the state.
  always_comb begin
    pr_req_s = {PROB_W{1'b0}};
    pr_rsp_s = {PROB_W{1'b0}};
    case (state_s)
      ST_SREQ: pr_req_s = PR_HI;
      ST_SRSP: pr_rsp_s = PR_HI;
      default: begin
        pr_req_s = {PROB_W{1'b0}};
        pr_rsp_s = {PROB_W{1'b0}};
      end
    endcase
  end

  // Counters, sticky error flag and registered probability outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pr_req_r <= {PROB_W{1'b0}};
      pr_rsp_r <= {PROB_W{1'b0}};
      wr_out_r <= {CNT_W{1'b0}};
      rd_out_r <= {CNT_W{1'b0}};
      nwr_r    <= {CNT_W{1'b0}};
      nrd_r    <= {CNT_W{1'b0}};
      phase_r  <= {CNT_W{1'b0}};
      wd_r     <= {TIMEOUT_W{1'b0}};
      proto_r  <= 1'b0;
    end else begin
      pr_req_r <= pr_req_s;
      pr_rsp_r <= pr_rsp_s;
      wr_out_r <= wr_out_s;
      rd_out_r <= rd_out_s;
      proto_r  <= proto_r || wr_err_s || rd_err_s;
      if (start_ok_s) begin
        nwr_r <= {CNT_W{1'b0}};
        nrd_r <= {CNT_W{1'b0}};
      end else begin
        nwr_r <= hs_b_s ? sat_inc(nwr_r) : nwr_r;
        nrd_r <= hs_r_s ? sat_inc(nrd_r) : nrd_r;
      end
      if ((state_s != state_r) || !in_phase_s) phase_r <= {CNT_W{1'b0}};
      else                                     phase_r <= phase_sum_s[CNT_W-1:0];
      if ((state_s != state_r) || any_hs_s) wd_r <= {TIMEOUT_W{1'b0}};
      else if (active_s)                    wd_r <= wd_inc_s;
      else                                  wd_r <= wd_r;
    end
  end

  assign bus.pr_aw_stall = pr_req_r;
  assign bus.pr_w_stall  = pr_req_r;
  assign bus.pr_ar_stall = pr_req_r;
  assign bus.pr_b_stall  = pr_rsp_r;
  assign bus.pr_r_stall  = pr_rsp_r;
  assign o_state         = state_r;
  assign o_nWr           = nwr_r;
  assign o_nRd           = nrd_r;
  assign o_protoErr      = proto_r;

endmodule

// File: tb/tb_axi4lite_stress_sequencer.sv
// Directed, table-driven bench for the AXI4-Lite stress sequencer plus hand-written
// sequences for watchdog, abort, underflow and asynchronous reset.
module tb_axi4lite_stress_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] ptx;
  logic [11:0] tmo;
  logic [2:0]  state;
  logic [15:0] nwr;
  logic [15:0] nrd;
  logic        perr;

  int checks;
  int errors;

  axi4lite_stress_sequencer_if #(.PROB_W(8)) bus ();

  axi4lite_stress_sequencer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_abort     (abort),
    .i_phaseTxns (ptx),
    .i_timeout   (tmo),
    .bus         (bus),
    .o_state     (state),
    .o_nWr       (nwr),
    .o_nRd       (nrd),
    .o_protoErr  (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [15:0] ptx;
    logic [4:0]  hs;
    logic [2:0]  exp_st;
    logic [7:0]  exp_req;
    logic [7:0]  exp_rsp;
    logic [15:0] exp_nwr;
    logic [15:0] exp_nrd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic st, input logic [15:0] p, input logic [4:0] h,
                              input logic [2:0] s, input logic [7:0] rq, input logic [7:0] rs,
                              input logic [15:0] nw, input logic [15:0] nr);
    vec_t v;
    v.st = st; v.ptx = p; v.hs = h; v.exp_st = s;
    v.exp_req = rq; v.exp_rsp = rs; v.exp_nwr = nw; v.exp_nrd = nr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] s, input logic [7:0] rq,
                         input logic [7:0] rs, input logic [15:0] nw, input logic [15:0] nr,
                         input logic er);
    chk({tag, ".state"}, {29'd0, state}, {29'd0, s});
    chk({tag, ".pr_aw"}, {24'd0, bus.pr_aw_stall}, {24'd0, rq});
    chk({tag, ".pr_w"},  {24'd0, bus.pr_w_stall},  {24'd0, rq});
    chk({tag, ".pr_ar"}, {24'd0, bus.pr_ar_stall}, {24'd0, rq});
    chk({tag, ".pr_b"},  {24'd0, bus.pr_b_stall},  {24'd0, rs});
    chk({tag, ".pr_r"},  {24'd0, bus.pr_r_stall},  {24'd0, rs});
    chk({tag, ".nWr"},   {16'd0, nwr}, {16'd0, nw});
    chk({tag, ".nRd"},   {16'd0, nrd}, {16'd0, nr});
    chk({tag, ".err"},   {31'd0, perr}, {31'd0, er});
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic st, input logic ab, input logic [4:0] h);
    start  = st;
    abort  = ab;
    bus.hs = h;
    @(posedge clk);
    #1;
    start  = 1'b0;
    abort  = 1'b0;
    bus.hs = 5'b00000;
  endtask

  localparam logic [4:0] HS_REQ = 5'b01011;  // AW, W, AR
  localparam logic [4:0] HS_RSP = 5'b10100;  // B, R
  localparam logic [7:0] HI     = 8'hC0;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    ptx    = 16'd4;
    tmo    = 12'd0;
    bus.hs = 5'b00000;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk_all("reset", 3'd0, 8'h00, 8'h00, 16'd0, 16'd0, 1'b0);

    // Full sequence with phaseTxns=4, then a phaseTxns=0 sequence.
    vq.push_back(mk(1'b1, 16'd4, 5'b00000, 3'd1, 8'h00, 8'h00, 16'd0, 16'd0));
    vq.push_back(mk(1'b0, 16'd4, HS_REQ,   3'd1, 8'h00, 8'h00, 16'd0, 16'd0));
    vq.push_back(mk(1'b0, 16'd4, HS_RSP,   3'd1, 8'h00, 8'h00, 16'd1, 16'd1));
    vq.push_back(mk(1'b0, 16'd4, HS_REQ,   3'd1, 8'h00, 8'h00, 16'd1, 16'd1));
    vq.push_back(mk(1'b0, 16'd4, HS_RSP,   3'd2, HI,    8'h00, 16'd2, 16'd2));
    vq.push_back(mk(1'b0, 16'd4, HS_REQ,   3'd2, HI,    8'h00, 16'd2, 16'd2));
    vq.push_back(mk(1'b0, 16'd4, HS_RSP,   3'd2, HI,    8'h00, 16'd3, 16'd3));
    vq.push_back(mk(1'b0, 16'd4, HS_REQ,   3'd2, HI,    8'h00, 16'd3, 16'd3));
    vq.push_back(mk(1'b0, 16'd4, HS_RSP,   3'd3, 8'h00, HI,    16'd4, 16'd4));
    vq.push_back(mk(1'b0, 16'd4, HS_REQ,   3'd3, 8'h00, HI,    16'd4, 16'd4));
    vq.push_back(mk(1'b0, 16'd4, HS_RSP,   3'd3, 8'h00, HI,    16'd5, 16'd5));
    vq.push_back(mk(1'b0, 16'd4, HS_REQ,   3'd3, 8'h00, HI,    16'd5, 16'd5));
    vq.push_back(mk(1'b0, 16'd4, HS_RSP,   3'd4, 8'h00, 8'h00, 16'd6, 16'd6));
    vq.push_back(mk(1'b0, 16'd4, 5'b00000, 3'd5, 8'h00, 8'h00, 16'd6, 16'd6));
    vq.push_back(mk(1'b0, 16'd4, 5'b00000, 3'd5, 8'h00, 8'h00, 16'd6, 16'd6));
    vq.push_back(mk(1'b1, 16'd0, 5'b00000, 3'd1, 8'h00, 8'h00, 16'd0, 16'd0));
    vq.push_back(mk(1'b0, 16'd0, 5'b00000, 3'd2, HI,    8'h00, 16'd0, 16'd0));
    vq.push_back(mk(1'b0, 16'd0, 5'b00000, 3'd3, 8'h00, HI,    16'd0, 16'd0));
    vq.push_back(mk(1'b0, 16'd0, 5'b00000, 3'd4, 8'h00, 8'h00, 16'd0, 16'd0));
    vq.push_back(mk(1'b0, 16'd0, 5'b00000, 3'd5, 8'h00, 8'h00, 16'd0, 16'd0));

    for (int i = 0; i < vq.size(); i++) begin
      ptx = vq[i].ptx;
      step(vq[i].st, 1'b0, vq[i].hs);
      chk_all($sformatf("vec%0d", i), vq[i].exp_st, vq[i].exp_req, vq[i].exp_rsp,
              vq[i].exp_nwr, vq[i].exp_nrd, 1'b0);
    end

    // Watchdog: 10 idle cycles after start reach HANG, start recovers.
    ptx = 16'd4;
    tmo = 12'd10;
    step(1'b1, 1'b0, 5'b00000);
    chk("wd.start", {29'd0, state}, 32'd1);
    for (int i = 1; i <= 9; i++) step(1'b0, 1'b0, 5'b00000);
    chk("wd.count9", {29'd0, state}, 32'd1);
    step(1'b0, 1'b0, 5'b00000);
    chk_all("wd.hang", 3'd6, 8'h00, 8'h00, 16'd0, 16'd0, 1'b0);
    step(1'b1, 1'b0, 5'b00000);
    chk("wd.restart", {29'd0, state}, 32'd1);

    // Abort from STRESS_REQ with three writes outstanding.
    tmo = 12'd0;
    ptx = 16'd2;
    step(1'b0, 1'b0, 5'b11101);
    chk_all("ab.sreq", 3'd2, HI, 8'h00, 16'd1, 16'd1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'b00001);
    chk("ab.still_sreq", {29'd0, state}, 32'd2);
    step(1'b0, 1'b1, 5'b00000);
    chk_all("ab.drain", 3'd4, 8'h00, 8'h00, 16'd1, 16'd1, 1'b0);
    step(1'b0, 1'b0, 5'b00100);
    step(1'b0, 1'b0, 5'b00100);
    chk_all("ab.drain2", 3'd4, 8'h00, 8'h00, 16'd3, 16'd1, 1'b0);
    step(1'b0, 1'b0, 5'b00100);
    chk_all("ab.done", 3'd5, 8'h00, 8'h00, 16'd4, 16'd1, 1'b0);

    // Write response with nothing outstanding: sticky error survives start.
    step(1'b0, 1'b0, 5'b00100);
    chk_all("pe.set", 3'd5, 8'h00, 8'h00, 16'd5, 16'd1, 1'b1);
    ptx = 16'd0;
    step(1'b1, 1'b0, 5'b00000);
    chk_all("pe.start", 3'd1, 8'h00, 8'h00, 16'd0, 16'd0, 1'b1);
    step(1'b0, 1'b0, 5'b00000);
    step(1'b0, 1'b0, 5'b00000);
    chk_all("rst.srsp", 3'd3, 8'h00, HI, 16'd0, 16'd0, 1'b1);

    // Asynchronous reset between edges.
    rst_n = 1'b0;
    #2;
    chk_all("rst.async", 3'd0, 8'h00, 8'h00, 16'd0, 16'd0, 1'b0);
    #10 rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
